// File: rtl/fp_div_special_case_pipe.sv
// fp_div_special_case_pipe: pipelined IEEE-754 divide special-case handler with tag, sticky flags and valid/ready flow control
//
// Sits beside the iterative mantissa divider. Each operand pair is classified in S1.
// S2 then holds either a final special result (NaN/Inf/zero) or a bypass indication,
// which tells the datapath to use the divider result instead.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              operand handshake
//   in_dividend, in_divisor        operands a and b (DATA_WIDTH)
//   in_tag                         opaque request tag (TAG_WIDTH)
//   out_valid/out_ready            result handshake
//   out_bypass                     1 = not a special case, use divider result (out_result is 0)
//   out_result, out_tag            special-case result and its tag
//   out_invalid, out_div_zero      per-result exception events
//   flags_clr                      synchronous clear of the sticky flags
//   sticky_invalid/sticky_div_zero accumulated exception flags
//
// Build option: define FP_DIV_DENORM_FLUSH_EN to treat subnormal operands as zero.
`timescale 1ns/1ps
module fp_div_special_case_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int TAG_WIDTH = 4,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_dividend,
    input  logic [DATA_WIDTH-1:0] in_divisor,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bypass,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_invalid,
    output logic                  out_div_zero,
    input  logic                  flags_clr,
    output logic                  sticky_invalid,
    output logic                  sticky_div_zero
);
`ifdef FP_DIV_DENORM_FLUSH_EN
    localparam logic FLUSH = 1'b1;
`else
    localparam logic FLUSH = 1'b0;
`endif
    localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

    // Class bits: [3] nan, [2] signalling nan, [1] inf, [0] zero (subnormals fold in when flushing)
    function automatic logic [3:0] classify(input logic [DATA_WIDTH-2:0] x);
        logic e_ones, e_zero, f_zero;
        e_ones = &x[DATA_WIDTH-2:MAN_WIDTH];
        e_zero = ~|x[DATA_WIDTH-2:MAN_WIDTH];
        f_zero = ~|x[MAN_WIDTH-1:0];
        return {e_ones & !f_zero, e_ones & !f_zero & !x[MAN_WIDTH-1], e_ones & f_zero, e_zero & (f_zero | FLUSH)};
    endfunction

    logic                  s1_valid, s1_sign;
    logic [3:0]            s1_a, s1_b;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s1_adv, s2_adv, hs;
    logic                  r_bypass, r_inv, r_dz;
    logic [DATA_WIDTH-1:0] r_res;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign hs       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_dividend[DATA_WIDTH-1] ^ in_divisor[DATA_WIDTH-1];
                s1_a    <= classify(in_dividend[DATA_WIDTH-2:0]);
                s1_b    <= classify(in_divisor[DATA_WIDTH-2:0]);
                s1_tag  <= in_tag;
            end
        end
    end

    // Priority chain: earlier branches shadow later ones, so each test may assume
    // neither operand matched any earlier case (e.g. "b zero" implies a finite nonzero).
    always_comb begin
        r_bypass = 1'b0;
        r_inv    = 1'b0;
        r_dz     = 1'b0;
        r_res    = '0;
        if (s1_a[3] || s1_b[3]) begin
            r_res = QNAN;
            r_inv = s1_a[2] || s1_b[2];
        end else if ((s1_a[1] && s1_b[1]) || (s1_a[0] && s1_b[0])) begin
            r_res = QNAN;
            r_inv = 1'b1;
        end else if (s1_a[1]) begin
            r_res = {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        end else if (s1_b[1]) begin
            r_res = {s1_sign, {(DATA_WIDTH-1){1'b0}}};
        end else if (s1_b[0]) begin
            r_res = {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            r_dz  = 1'b1;
        end else if (s1_a[0]) begin
            r_res = {s1_sign, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r_bypass = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_bypass   <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            out_invalid  <= 1'b0;
            out_div_zero <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_bypass   <= r_bypass;
                out_result   <= r_res;
                out_tag      <= s1_tag;
                out_invalid  <= r_inv;
                out_div_zero <= r_dz;
            end
        end
    end

    // Clear takes effect first, so a flagged handshake in the same cycle still sets the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_invalid  <= 1'b0;
            sticky_div_zero <= 1'b0;
        end else begin
            sticky_invalid  <= (sticky_invalid & !flags_clr) | (hs & out_invalid);
            sticky_div_zero <= (sticky_div_zero & !flags_clr) | (hs & out_div_zero);
        end
    end
endmodule

// File: tb/tb_fp_div_special_case_pipe.sv
// tb_fp_div_special_case_pipe: self-checking bench for fp_div_special_case_pipe (default 32-bit format)
`timescale 1ns/1ps
module tb_fp_div_special_case_pipe;
`ifdef FP_DIV_DENORM_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flags_clr = 1'b0;
    logic [31:0] in_dividend = '0, in_divisor = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, out_bypass, out_invalid, out_div_zero, sticky_invalid, sticky_div_zero;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    int          passed = 0, total = 0;

    fp_div_special_case_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_bypass(out_bypass),
        .out_result(out_result), .out_tag(out_tag), .out_invalid(out_invalid),
        .out_div_zero(out_div_zero), .flags_clr(flags_clr),
        .sticky_invalid(sticky_invalid), .sticky_div_zero(sticky_div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    typedef enum logic [2:0] {K_ZERO, K_FIN, K_INF, K_QNAN, K_SNAN} kind_e;
    typedef struct packed {logic byp; logic [31:0] res; logic inv; logic dz;} exp_t;
    typedef struct packed {logic [3:0] tag; exp_t e;} sb_t;
    typedef struct packed {logic [31:0] a, b, res; logic byp, inv, dz;} dvec_t;

    function automatic kind_e kind(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return x[22:0] == 0 ? K_INF : (x[22] ? K_QNAN : K_SNAN);
        if (x[30:23] == 8'h00 && (x[22:0] == 0 || FLUSH)) return K_ZERO;
        return K_FIN;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        kind_e ka = kind(a);
        kind_e kb = kind(b);
        logic  s = a[31] ^ b[31];
        exp_t  r = '0;
        if (ka inside {K_QNAN, K_SNAN} || kb inside {K_QNAN, K_SNAN}) begin
            r.res = QNAN;
            r.inv = (ka == K_SNAN) || (kb == K_SNAN);
        end else if ((ka == K_INF && kb == K_INF) || (ka == K_ZERO && kb == K_ZERO)) begin
            r.res = QNAN;
            r.inv = 1'b1;
        end else if (ka == K_INF) r.res = {s, 8'hFF, 23'h0};
        else if (kb == K_INF) r.res = {s, 31'h0};
        else if (kb == K_ZERO) begin
            r.res = {s, 8'hFF, 23'h0};
            r.dz  = 1'b1;
        end else if (ka == K_ZERO) r.res = {s, 31'h0};
        else r.byp = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic s = 1'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 31'h0};
            1: return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, 1'b1, 22'($urandom)};
            4: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_during out_valid got %b want 0", out_valid); else passed++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero, sticky_invalid, sticky_div_zero} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0})
            $display("FAIL reset_state got rdy=%b v=%b byp=%b res=%h tag=%h inv=%b dz=%b si=%b sdz=%b want rdy=1, rest 0",
                     in_ready, out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero, sticky_invalid, sticky_div_zero);
        else passed++;
    endtask

    task automatic test_special_cases();
        dvec_t dv[13];
        logic  esi = 1'b0, edz = 1'b0;
        dv = '{
            {32'h00000000, 32'h00000000, QNAN,         1'b0, 1'b1, 1'b0},
            {32'hC0000000, 32'h80000000, 32'h7F800000, 1'b0, 1'b0, 1'b1},
            {32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1'b0},
            {32'h7F800001, 32'h3F800000, QNAN,         1'b0, 1'b1, 1'b0},
            {32'h7FC00000, 32'h3F800000, QNAN,         1'b0, 1'b0, 1'b0},
            {32'h7F800000, 32'hFF800000, QNAN,         1'b0, 1'b1, 1'b0},
            {32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 1'b0},
            {32'h80000000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 1'b0},
            FLUSH ? {32'h00000001, 32'h00000001, QNAN, 1'b0, 1'b1, 1'b0}
                  : {32'h00000001, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b0},
            FLUSH ? {32'h3F800000, 32'h00000001, 32'h7F800000, 1'b0, 1'b0, 1'b1}
                  : {32'h3F800000, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b0},
            FLUSH ? {32'h80000001, 32'h00000000, QNAN, 1'b0, 1'b1, 1'b0}
                  : {32'h80000001, 32'h00000000, 32'hFF800000, 1'b0, 1'b0, 1'b1},
            {32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 1'b0, 1'b0},
            {32'h7FC00000, 32'h7F800001, QNAN,         1'b0, 1'b1, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_dividend = dv[i].a; in_divisor = dv[i].b; in_tag = 4'(i);
            @(negedge clk);
            total++; if (in_ready !== 1'b1) $display("FAIL vec%0d in_ready got %b want 1", i, in_ready); else passed++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            total++; if (out_valid !== 1'b0) $display("FAIL vec%0d early out_valid got %b want 0", i, out_valid); else passed++;
            @(negedge clk);
            total++;
            if ({out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero} !== {1'b1, dv[i].byp, dv[i].res, 4'(i), dv[i].inv, dv[i].dz})
                $display("FAIL vec%0d %h/%h got v=%b byp=%b res=%h tag=%h inv=%b dz=%b want v=1 byp=%b res=%h tag=%h inv=%b dz=%b",
                         i, dv[i].a, dv[i].b, out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero,
                         dv[i].byp, dv[i].res, 4'(i), dv[i].inv, dv[i].dz);
            else passed++;
            esi |= dv[i].inv;
            edz |= dv[i].dz;
            @(negedge clk);
            total++;
            if ({out_valid, sticky_invalid, sticky_div_zero} !== {1'b0, esi, edz})
                $display("FAIL vec%0d sticky got v=%b si=%b sdz=%b want v=0 si=%b sdz=%b", i, out_valid, sticky_invalid, sticky_div_zero, esi, edz);
            else passed++;
        end
    endtask

    task automatic test_flags_clr();
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
        @(negedge clk);
        total++; if ({sticky_invalid, sticky_div_zero} !== 2'b00) $display("FAIL clr_alone got %b%b want 00", sticky_invalid, sticky_div_zero); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b1; in_dividend = 32'h0; in_divisor = 32'h0; in_tag = 4'h9;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 flags_clr = 1'b1;
        @(negedge clk);
        total++; if ({out_valid, out_invalid} !== 2'b11) $display("FAIL clr_hs_setup got v=%b inv=%b want 11", out_valid, out_invalid); else passed++;
        @(negedge clk);
        total++; if (sticky_invalid !== 1'b1) $display("FAIL clr_with_event sticky_invalid got %b want 1", sticky_invalid); else passed++;
        @(posedge clk); #1 flags_clr = 1'b0;
        @(negedge clk);
        total++; if (sticky_invalid !== 1'b0) $display("FAIL clr_next sticky_invalid got %b want 0", sticky_invalid); else passed++;
    endtask

    task automatic test_back_to_back();
        int    sent = 0, got = 0;
        logic  stalled = 1'b0, saw_block = 1'b0;
        logic [39:0] held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid = sent < 4;
            in_dividend = 32'h40000000 + 32'(sent);
            in_divisor = 32'h3F800000;
            in_tag = 4'(sent);
            @(negedge clk);
            if (!in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) sent++;
            if (stalled) begin
                total++;
                if ({out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero} !== held)
                    $display("FAIL stall_stable cyc%0d got %h want %h", cyc, {out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero}, held);
                else passed++;
            end
            stalled = out_valid && !out_ready;
            held = {out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero};
            if (out_valid && out_ready) begin
                total++;
                if ({out_tag, out_bypass, out_result} !== {4'(got), 1'b1, 32'h0})
                    $display("FAIL b2b_order got tag=%h byp=%b res=%h want tag=%h byp=1 res=0", out_tag, out_bypass, out_result, 4'(got));
                else passed++;
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (sent != 4 || got != 4) $display("FAIL b2b_count got sent=%0d recv=%0d want 4/4", sent, got); else passed++;
        total++; if (saw_block !== 1'b1) $display("FAIL b2b_in_ready_drop got %b want 1", saw_block); else passed++;
    endtask

    task automatic test_random();
        sb_t  q[$];
        sb_t  x;
        logic esi = 1'b0, edz = 1'b0, hs, stalled = 1'b0;
        logic [39:0] held = '0;
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge clk); #1;
            in_valid = cyc < 400 && ($urandom_range(0, 3) != 0);
            in_dividend = rand_op();
            in_divisor = rand_op();
            in_tag = 4'($urandom);
            out_ready = cyc >= 400 || ($urandom_range(0, 9) < 7);
            flags_clr = $urandom_range(0, 15) == 0;
            @(negedge clk);
            total++;
            if ({sticky_invalid, sticky_div_zero} !== {esi, edz})
                $display("FAIL rnd_sticky cyc%0d got %b%b want %b%b", cyc, sticky_invalid, sticky_div_zero, esi, edz);
            else passed++;
            if (stalled) begin
                total++;
                if ({out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero} !== held)
                    $display("FAIL rnd_stall_stable cyc%0d got %h want %h", cyc, {out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero}, held);
                else passed++;
            end
            stalled = out_valid && !out_ready;
            held = {out_valid, out_bypass, out_result, out_tag, out_invalid, out_div_zero};
            hs = out_valid && out_ready;
            x = '0;
            if (hs) begin
                total++;
                if (q.size() == 0) $display("FAIL rnd_unexpected cyc%0d got tag=%h want no output", cyc, out_tag);
                else begin
                    x = q.pop_front();
                    if ({out_tag, out_bypass, out_result, out_invalid, out_div_zero} !== x)
                        $display("FAIL rnd_result cyc%0d got tag=%h byp=%b res=%h inv=%b dz=%b want tag=%h byp=%b res=%h inv=%b dz=%b",
                                 cyc, out_tag, out_bypass, out_result, out_invalid, out_div_zero, x.tag, x.e.byp, x.e.res, x.e.inv, x.e.dz);
                    else passed++;
                end
            end
            esi = (esi && !flags_clr) || x.e.inv;
            edz = (edz && !flags_clr) || x.e.dz;
            if (in_valid && in_ready) q.push_back({in_tag, model(in_dividend, in_divisor)});
        end
        flags_clr = 1'b0;
        in_valid = 1'b0;
        total++; if (q.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", q.size()); else passed++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_dividend = 32'h0; in_divisor = 32'h0; in_tag = 4'h1;
        @(posedge clk); #1 out_ready = 1'b0;
        in_dividend = 32'h3F800000; in_divisor = 32'h40000000; in_tag = 4'h2;
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_tag, sticky_invalid} !== {1'b1, 4'h2, 1'b1})
            $display("FAIL mid_setup got v=%b tag=%h si=%b want v=1 tag=2 si=1", out_valid, out_tag, sticky_invalid);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sticky_invalid, sticky_div_zero, in_ready} !== 4'b0001)
            $display("FAIL mid_reset got v=%b si=%b sdz=%b rdy=%b want v=0 si=0 sdz=0 rdy=1", out_valid, sticky_invalid, sticky_div_zero, in_ready);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready} !== 2'b01) $display("FAIL mid_after%0d got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_special_cases();
        test_flags_clr();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
